// File: rtl/demosaic_mul_pipe.sv
// Pipelined signed x unsigned multiplier with round/shift/narrow and valid/ready + ce flow control.
// Define DEMOSAIC_MUL_SAT_EN to clip the result to OUT_WIDTH and flag it on out_sat; otherwise it wraps.
module demosaic_mul_pipe #(
    parameter int ID        = 1,
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 18,
    parameter int SHIFT     = 0,
    parameter int OUT_WIDTH = 26,
    parameter int NUM_STAGE = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 out_sat
);

    localparam int FW = A_WIDTH + B_WIDTH;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [FW:0] RND = (SHIFT > 0) ? ((FW + 1)'(1) << RND_SH) : '0;

    // Handshake: a stage moves only when ce is high and the output slot is empty or being taken.
    // in_ready equals that advance strobe; an input transfers on in_valid & in_ready, an output on
    // out_valid & out_ready while ce is high.
    logic                 adv;
    logic [NUM_STAGE-1:0] vld;
    logic signed [FW-1:0] full_c;

    assign adv       = ce & (~out_valid | out_ready);
    assign in_ready  = adv;
    assign out_valid = vld[NUM_STAGE-1];
    assign full_c    = $signed({{B_WIDTH{din0[A_WIDTH-1]}}, din0})
                     * $signed({{A_WIDTH{1'b0}}, din1});

    // Rounding add is one bit wider than the product so it cannot overflow.
    function automatic logic signed [FW:0] round_shift(input logic signed [FW-1:0] full);
        logic signed [FW:0] ext;
        ext = {full[FW-1], full} + RND;
        return ext >>> SHIFT;
    endfunction

`ifdef DEMOSAIC_MUL_SAT_EN
    localparam int NW = OUT_WIDTH + 1;
    localparam logic signed [FW:0] MAXV =
        $signed({{(FW + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}});
    localparam logic signed [FW:0] MINV = ~MAXV;
    localparam logic [OUT_WIDTH-1:0] MAXO = {1'b0, {(OUT_WIDTH - 1){1'b1}}};

    // Returns {clipped, value}.
    function automatic logic [NW-1:0] narrow(input logic signed [FW-1:0] full);
        logic signed [FW:0] r;
        r = round_shift(full);
        if (r > MAXV) begin
            return {1'b1, MAXO};
        end else if (r < MINV) begin
            return {1'b1, ~MAXO};
        end
        return {1'b0, OUT_WIDTH'(r)};
    endfunction
`else
    localparam int NW = OUT_WIDTH;

    function automatic logic [NW-1:0] narrow(input logic signed [FW-1:0] full);
        return OUT_WIDTH'(round_shift(full));
    endfunction
`endif

    logic [NW-1:0] res_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
        end else if (adv) begin
            vld <= NUM_STAGE'({vld, in_valid});
        end
    end

    generate
        if (NUM_STAGE == 1) begin : g_single
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    res_q <= '0;
                end else if (adv) begin
                    res_q <= narrow(full_c);
                end
            end
        end else begin : g_deep
            // pipe[0] holds the raw product; later entries are retiming registers.
            logic signed [FW-1:0] pipe [NUM_STAGE-1];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < NUM_STAGE - 1; k++) begin
                        pipe[k] <= '0;
                    end
                    res_q <= '0;
                end else if (adv) begin
                    pipe[0] <= full_c;
                    for (int k = 1; k < NUM_STAGE - 1; k++) begin
                        pipe[k] <= pipe[k-1];
                    end
                    res_q <= narrow(pipe[NUM_STAGE-2]);
                end
            end
        end
    endgenerate

    assign dout = res_q[OUT_WIDTH-1:0];

`ifdef DEMOSAIC_MUL_SAT_EN
    assign out_sat = res_q[OUT_WIDTH];
`else
    assign out_sat = 1'b0;
`endif

endmodule
